// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, LCD command words and build options for lcd_sequencer
// Build option: define LCD_CURSOR_BLINK_EN for a blinking cursor that tracks the last host write.
package lcd_pkg;
  typedef enum logic [3:0] {
    PWR_WAIT, NIB_SETUP, NIB_E, NIB_WAIT,
    CMD_ISSUE, CMD_WAIT, CMD_DELAY,
    REF_ISSUE, REF_WAIT
  } state_t;
  localparam logic [9:0] FUNC_SET      = 10'h028;
  localparam logic [9:0] ENTRY_MODE    = 10'h006;
  localparam logic [9:0] DISP_ON       = 10'h00C;
  localparam logic [9:0] DISP_ON_BLINK = 10'h00F;
  localparam logic [9:0] CLEAR         = 10'h001;
  localparam logic [9:0] LINE1_ADDR    = 10'h080;
  localparam logic [9:0] LINE2_ADDR    = 10'h0C0;
  localparam logic [1:0] DATA_WR       = 2'b10;
`ifdef LCD_CURSOR_BLINK_EN
  localparam bit CURSOR_BLINK = 1'b1;
`else
  localparam bit CURSOR_BLINK = 1'b0;
`endif
  localparam logic [9:0] CFG_DISP = CURSOR_BLINK ? DISP_ON_BLINK : DISP_ON;
  // index of the final refresh instruction before wrapping to LINE1_ADDR
  localparam logic [5:0] REF_LAST = CURSOR_BLINK ? 6'd34 : 6'd33;
  function automatic logic [9:0] cfg_cmd(input logic [1:0] k);
    return k == 2'd0 ? FUNC_SET : k == 2'd1 ? ENTRY_MODE : k == 2'd2 ? CFG_DISP : CLEAR;
  endfunction
endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: 20-bit down-counter shared by every timed wait of the sequencer
// clk, reset (async, active-low); load/load_val restart the count; expired is high while the count is 0.
module lcd_delay_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [19:0] load_val,
  output logic        expired
);
  logic [19:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= load ? load_val : cnt != 20'd0 ? cnt - 20'd1 : cnt;
  assign expired = cnt == 20'd0;
endmodule

// File: rtl/lcd_sequencer.sv
// lcd_sequencer: power-on nibble init, configuration and continuous refresh for the 2x16 character LCD
// clk, reset (async, active-low); wr_en/wr_addr/wr_data write the 32-byte character buffer;
// done/inst_* come from the instruction engine, next_instruction/db drive it;
// SF_D/LCD_E/LCD_RS/LCD_RW are the LCD pins; init_done marks configuration complete.
// Build option: LCD_CURSOR_BLINK_EN appends a cursor-position instruction to every refresh pass.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned PWR_WAIT_CYC = 750000,
  parameter int unsigned NIB_E_CYC    = 12,
  parameter int unsigned NIB_GAP1_CYC = 205000,
  parameter int unsigned NIB_GAP_CYC  = 5000,
  parameter int unsigned NIB_GAP4_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       done,
  input  logic [3:0] inst_sf_d,
  input  logic       inst_e,
  input  logic       inst_rs,
  input  logic       inst_rw,
  output logic       next_instruction,
  output logic [9:0] db,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       init_done
);
  // PWR_WAIT spends its first cycle arming the counter, so it loads two short of the full wait
  localparam logic [19:0] PWR_LOAD  = 20'(PWR_WAIT_CYC - 2);
  localparam logic [19:0] E_LOAD    = 20'(NIB_E_CYC - 1);
  localparam logic [19:0] GAP1_LOAD = 20'(NIB_GAP1_CYC - 1);
  localparam logic [19:0] GAP_LOAD  = 20'(NIB_GAP_CYC - 1);
  localparam logic [19:0] GAP4_LOAD = 20'(NIB_GAP4_CYC - 1);
  localparam logic [19:0] CLR_LOAD  = 20'(CLR_WAIT_CYC - 1);
  state_t state, state_nx;
  logic [1:0] n, n_nx, k, k_nx;
  logic [5:0] r, r_nx, r_adv;
  logic [9:0] db_nx, ref_word, ref_tail;
  logic init_nx, armed, armed_nx, load, expired, raw;
  logic [19:0] load_val;
  logic [7:0] chars [32];
  lcd_delay_cnt u_dly (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) chars[i] <= 8'h20;
    else if (wr_en) chars[wr_addr] <= wr_data;
`ifdef LCD_CURSOR_BLINK_EN
  logic [6:0] cursor;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cursor <= '0;
    else if (wr_en) cursor <= {wr_addr[4], 2'b00, wr_addr[3:0]};
  assign ref_tail = LINE1_ADDR | {3'b000, cursor};
`else
  assign ref_tail = LINE1_ADDR;
`endif
  // index of the refresh instruction that follows the one in flight (0 when entering refresh)
  assign r_adv = (state == REF_WAIT && r != REF_LAST) ? r + 6'd1 : 6'd0;
  always_comb
    ref_word = r_adv == 6'd0 ? LINE1_ADDR :
               r_adv < 6'd17 ? {DATA_WR, chars[5'(r_adv - 6'd1)]} :
               r_adv == 6'd17 ? LINE2_ADDR :
               r_adv < 6'd34 ? {DATA_WR, chars[5'(r_adv - 6'd2)]} : ref_tail;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= PWR_WAIT;
      n         <= '0;
      k         <= '0;
      r         <= '0;
      db        <= '0;
      init_done <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nx;
      n         <= n_nx;
      k         <= k_nx;
      r         <= r_nx;
      db        <= db_nx;
      init_done <= init_nx;
      armed     <= armed_nx;
    end
  always_comb begin
    state_nx = state;
    n_nx     = n;
    k_nx     = k;
    r_nx     = r;
    db_nx    = db;
    init_nx  = init_done;
    armed_nx = armed;
    load     = 1'b0;
    load_val = '0;
    case (state)
      PWR_WAIT:
        if (!armed) begin
          armed_nx = 1'b1;
          load     = 1'b1;
          load_val = PWR_LOAD;
        end else if (expired) begin
          state_nx = NIB_SETUP;
          n_nx     = '0;
          load     = 1'b1;
          load_val = 20'd1;
        end
      NIB_SETUP:
        if (expired) begin
          state_nx = NIB_E;
          load     = 1'b1;
          load_val = E_LOAD;
        end
      NIB_E:
        if (expired) begin
          state_nx = NIB_WAIT;
          load     = 1'b1;
          load_val = n == 2'd0 ? GAP1_LOAD : n == 2'd3 ? GAP4_LOAD : GAP_LOAD;
        end
      NIB_WAIT:
        if (expired && n == 2'd3) begin
          state_nx = CMD_ISSUE;
          k_nx     = '0;
          db_nx    = cfg_cmd(2'd0);
        end else if (expired) begin
          state_nx = NIB_SETUP;
          n_nx     = n + 2'd1;
          load     = 1'b1;
          load_val = 20'd1;
        end
      CMD_ISSUE: state_nx = CMD_WAIT;
      CMD_WAIT:
        if (done && k == 2'd3) begin
          state_nx = CMD_DELAY;
          load     = 1'b1;
          load_val = CLR_LOAD;
        end else if (done) begin
          state_nx = CMD_ISSUE;
          k_nx     = k + 2'd1;
          db_nx    = cfg_cmd(k + 2'd1);
        end
      CMD_DELAY:
        if (expired) begin
          state_nx = REF_ISSUE;
          init_nx  = 1'b1;
          r_nx     = r_adv;
          db_nx    = ref_word;
        end
      REF_ISSUE: state_nx = REF_WAIT;
      REF_WAIT:
        if (done) begin
          state_nx = REF_ISSUE;
          r_nx     = r_adv;
          db_nx    = ref_word;
        end
      default: state_nx = PWR_WAIT;
    endcase
  end
  assign raw              = state inside {PWR_WAIT, NIB_SETUP, NIB_E, NIB_WAIT};
  assign next_instruction = state == CMD_ISSUE || state == REF_ISSUE;
  assign SF_D   = !raw ? inst_sf_d : state == PWR_WAIT ? 4'h0 : n == 2'd3 ? 4'h2 : 4'h3;
  assign LCD_E  = raw ? state == NIB_E : inst_e;
  assign LCD_RS = !raw && inst_rs;
  assign LCD_RW = !raw && inst_rw;
endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Sequences the two-nibble LCD instruction engine for the Spartan-3E 2x16 character LCD.
- After reset it runs the power-on nibble init and the configuration command list, then continuously refreshes both display lines from an internal 32-byte character buffer that the host writes.
- Owns the LCD pins. It drives them directly during raw nibble init and passes the engine's pins through afterwards.

Parameters:
- PWR_WAIT_CYC, 750000: power-on wait (15 ms at 50 MHz).
- NIB_E_CYC, 12: LCD_E high width for a raw init nibble (240 ns).
- NIB_GAP1_CYC, 205000: wait after the first init nibble (4.1 ms).
- NIB_GAP_CYC, 5000: wait after init nibbles 2 and 3 (100 us).
- NIB_GAP4_CYC, 2000: wait after init nibble 4 (40 us).
- CLR_WAIT_CYC, 82000: extra wait after the engine's done for Clear Display (1.64 ms).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe to the character buffer.
- wr_addr  in  5  buffer index: 0-15 is line 1, 16-31 is line 2.
- wr_data  in  8  ASCII character.
- done  in  1  engine has finished the current 10-bit instruction; one-cycle pulse.
- inst_sf_d  in  4  engine nibble output.
- inst_e  in  1  engine LCD_E output.
- inst_rs  in  1  engine LCD_RS output.
- inst_rw  in  1  engine LCD_RW output.
- next_instruction  out  1  one-cycle start pulse to the engine.
- db  out  10  {RS, RW, data[7:0]} presented to the engine.
- SF_D  out  4  LCD data nibble pins.
- LCD_E  out  1  LCD enable pin.
- LCD_RS  out  1  LCD register-select pin.
- LCD_RW  out  1  LCD read/write pin.
- init_done  out  1  high once configuration is complete.

Behaviour:
- Reset values while reset is low:
  - All outputs are 0: next_instruction, db, SF_D, LCD_E, LCD_RS, LCD_RW, init_done.
  - Every character-buffer entry is 0x20.
  - FSM is in PWR_WAIT and the delay counter is 0.
- Reset taken at any point, including mid-nibble or mid-command, returns to PWR_WAIT and restarts the full init.
- Pin mux:
  - States PWR_WAIT through NIB_WAIT: SF_D is the raw nibble register, LCD_E is the raw enable, LCD_RS = 0, LCD_RW = 0.
  - All other states: pins are driven from inst_* unchanged.
- PWR_WAIT: count PWR_WAIT_CYC cycles, then go to NIB_SETUP with nibble index n = 0.
- NIB_SETUP: SF_D = 0x3, or 0x2 for n = 3. Hold for 2 cycles, then go to NIB_E.
- NIB_E: LCD_E = 1 for NIB_E_CYC cycles, SF_D held. Then go to NIB_WAIT.
- NIB_WAIT:
  - LCD_E = 0, SF_D held.
  - Gap length by nibble: NIB_GAP1_CYC for n = 0, NIB_GAP_CYC for n = 1 and 2, NIB_GAP4_CYC for n = 3.
  - When the gap expires: if n < 3, increment n and go to NIB_SETUP; if n = 3, go to CMD_ISSUE with command index k = 0.
- Configuration list, k = 0 to 3: 0x028 Function Set, 0x006 Entry Mode, 0x00C Display On, 0x001 Clear.
- CMD_ISSUE: drive db and pulse next_instruction for exactly 1 cycle, then go to CMD_WAIT.
- CMD_WAIT:
  - Hold db until done.
  - On done: Clear (k = 3) goes to CMD_DELAY; otherwise increment k and go to CMD_ISSUE.
- CMD_DELAY: CLR_WAIT_CYC cycles, then set init_done = 1 and go to REFRESH.
- REFRESH sequences 34 instructions in a loop, each issued as one next_instruction pulse followed by a wait for done:
  - 0x080 (set DDRAM address, line 1).
  - buffer[0] through buffer[15], each as {2'b10, char}.
  - 0x0C0 (set DDRAM address, line 2).
  - buffer[16] through buffer[31].
  - After buffer[31], wrap to 0x080 indefinitely.
- init_done stays 1 until the next reset.
- next_instruction is never asserted while the engine is mid-transfer; the next pulse comes no earlier than 1 cycle after done.
- done received outside CMD_WAIT or REFRESH wait is ignored.
- Host writes:
  - Accepted every cycle, in any state including during init; they update the buffer on the next edge.
  - db captures the buffer byte in the issue cycle. A write to the slot being sent in that same cycle appears on the next refresh pass.
  - Back-to-back writes to the same address: the last one wins.

Optional Feature:
- Macro: LCD_CURSOR_BLINK_EN.
- Defined: the Display On command is 0x00F (cursor on, blink on), and after each full refresh pass the sequencer issues 0x080 | cursor_pos. cursor_pos is the last host wr_addr mapped to DDRAM (0-15 maps to 0x00-0x0F, 16-31 maps to 0x40-0x4F). The refresh loop is then 35 instructions.
- Undefined: Display On is 0x00C and the loop is 34 instructions.

Decomposition:
- Package lcd_pkg holds:
  - FSM state enum.
  - Command constants: FUNC_SET = 10'h028, ENTRY_MODE = 10'h006, DISP_ON = 10'h00C, DISP_ON_BLINK = 10'h00F, CLEAR = 10'h001, LINE1_ADDR = 10'h080, LINE2_ADDR = 10'h0C0.
  - DATA_WR prefix 2'b10.
- Sub-module lcd_delay_cnt: a 20-bit down-counter with load, load value and expired outputs, reset to 0 asynchronously. It is shared by all wait states.

Test Plan:
- Shrink the timing parameters to 50/4/20/10/5/30, release reset, and mock the engine to pulse done 40 cycles after each next_instruction.
- Power-on: SF_D follows 3, 3, 3, 2, each with exactly 4 cycles of LCD_E high and the 20/10/10/5 gaps. Then db = 028, 006, 00C, 001; then 30 idle cycles; then init_done = 1.
- Refresh with no writes: 34 next_instruction pulses in the order 080, 0x20 x16 with RS = 1, 0C0, 0x20 x16; then 080 again.
- Write wr_addr = 17, wr_data = 0x41 during init: on the first pass, instruction 19 has db = 10'h241.
- Assert reset low mid-way through nibble 2 and through a refresh data write: outputs go to 0 immediately, and after release the sequence restarts from PWR_WAIT with the buffer back to spaces.
- Pulse done spuriously during PWR_WAIT, and withhold done for 500 cycles in CMD_WAIT: no extra next_instruction and db held. With LCD_CURSOR_BLINK_EN defined, Display On is 00F and 080|cursor_pos follows each pass.
